// File: rtl/sift_seq_pkg.sv
// sift_seq_pkg: shared definitions for the SIFT stage sequencer.
//   - seq_state_t : sequencer state encoding
//   - OWN_*       : shared-resource owner codes published on owner_sel
//   - CNT_W_DEF / KPT_W_DEF : default counter and keypoint widths
//   - owner_of()  : owner code for a given state
package sift_seq_pkg;

    localparam int CNT_W_DEF = 24;
    localparam int KPT_W_DEF = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GAUSS  = 3'd1,
        ST_DETECT = 3'd2,
        ST_MATCH  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } seq_state_t;

    localparam logic [1:0] OWN_NONE   = 2'd0;
    localparam logic [1:0] OWN_GAUSS  = 2'd1;
    localparam logic [1:0] OWN_DETECT = 2'd2;
    localparam logic [1:0] OWN_MATCH  = 2'd3;

    function automatic logic [1:0] owner_of(input seq_state_t s);
        case (s)
            ST_GAUSS:  return OWN_GAUSS;
            ST_DETECT: return OWN_DETECT;
            ST_MATCH:  return OWN_MATCH;
            default:   return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/stage_timer.sv
// stage_timer: per-stage cycle counter for the SIFT stage sequencer.
// Optional feature macro: SEQ_WATCHDOG_EN (enables the timeout compare).
// Ports:
//   clk, rst (async, active-high)
//   restart : load the counter with 1 (state entry)
//   run     : sequencer is in an active stage; counter advances
//   cnt     : cycles spent in the current stage (1 on the entry cycle)
//   timeout : cnt reached TIMEOUT_LIMIT in an active stage
module stage_timer #(
    parameter int          CNT_W         = 24,
    parameter int unsigned TIMEOUT_LIMIT = 2**22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic             timeout
);

`ifdef SEQ_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= CNT_W'(1);
        end else if (restart) begin
            cnt <= CNT_W'(1);
        end else if (run && (cnt != {CNT_W{1'b1}})) begin
            // saturate rather than wrap so a very long stage never looks short
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = WD_ON && run && (cnt == CNT_W'(TIMEOUT_LIMIT));

endmodule

// File: rtl/sift_stage_sequencer.sv
// sift_stage_sequencer: phase controller for the SIFT core.
// Steps GAUSS -> DETECT -> MATCH -> DONE, drives one enable per phase,
// publishes the shared-resource owner, latches the keypoint count and
// reports per-stage cycle counts.
// Optional feature macro: SEQ_WATCHDOG_EN (stage timeout -> ERROR).
// Ports:
//   clk, rst (async, active-high)
//   start, abort                          : run control
//   gauss_done, detect_done, match_done   : stage completion (level or pulse)
//   detect_kpt_addr                       : running keypoint address from detect
//   gauss_start, detect_start, match_start: stage enables (high for whole stage)
//   owner_sel                             : 0 none, 1 gauss, 2 detect, 3 match
//   keypoint_num                          : latched keypoint count
//   busy, done, err                       : status decodes
//   err_stage                             : owner code of the stage that timed out
//   last_cycles                           : length of the last completed stage
//
// state     | meaning
// ----------+------------------------------------------
// ST_IDLE   | waiting for start
// ST_GAUSS  | Gaussian blur running
// ST_DETECT | keypoint detect/filter running
// ST_MATCH  | descriptor compute/match running
// ST_DONE   | run complete, start restarts
// ST_ERROR  | a stage timed out, start restarts
module sift_stage_sequencer
    import sift_seq_pkg::*;
#(
    parameter int          CNT_W         = CNT_W_DEF,
    parameter int          KPT_W         = KPT_W_DEF,
    parameter int unsigned TIMEOUT_LIMIT = 2**22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             gauss_done,
    input  logic             detect_done,
    input  logic             match_done,
    input  logic [KPT_W-1:0] detect_kpt_addr,
    output logic             gauss_start,
    output logic             detect_start,
    output logic             match_start,
    output logic [1:0]       owner_sel,
    output logic [KPT_W-1:0] keypoint_num,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_stage,
    output logic [CNT_W-1:0] last_cycles
);

    seq_state_t       state_q, state_d;
    logic             first_q;
    logic             stage_done;
    logic             stage_fin;
    logic             restart;
    logic             timeout;
    logic [CNT_W-1:0] cnt;

    assign busy    = (state_q == ST_GAUSS) || (state_q == ST_DETECT) || (state_q == ST_MATCH);
    assign restart = (state_d != state_q);

    stage_timer #(
        .CNT_W         (CNT_W),
        .TIMEOUT_LIMIT (TIMEOUT_LIMIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .run     (busy),
        .cnt     (cnt),
        .timeout (timeout)
    );

    always_comb begin
        stage_done = 1'b0;
        case (state_q)
            ST_GAUSS:  stage_done = gauss_done;
            ST_DETECT: stage_done = detect_done;
            ST_MATCH:  stage_done = match_done;
            default:   stage_done = 1'b0;
        endcase
    end

    // a done level left over from the previous run must not skip the stage
    assign stage_fin = stage_done && !first_q;

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (start) state_d = ST_GAUSS;
                ST_GAUSS:  if (stage_fin) state_d = ST_DETECT;
                           else if (timeout) state_d = ST_ERROR;
                ST_DETECT: if (stage_fin) state_d = ST_MATCH;
                           else if (timeout) state_d = ST_ERROR;
                ST_MATCH:  if (stage_fin) state_d = ST_DONE;
                           else if (timeout) state_d = ST_ERROR;
                ST_DONE:   if (start) state_d = ST_GAUSS;
                ST_ERROR:  if (start) state_d = ST_GAUSS;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            first_q      <= 1'b0;
            keypoint_num <= '0;
            last_cycles  <= '0;
        end else begin
            state_q <= state_d;
            first_q <= restart;
            if (!abort && stage_fin) begin
                last_cycles <= cnt;
            end
            if ((state_d == ST_GAUSS) && (state_q != ST_GAUSS)) begin
                keypoint_num <= '0;
            end else if (!abort && (state_q == ST_DETECT)) begin
                keypoint_num <= detect_kpt_addr;
            end
        end
    end

`ifdef SEQ_WATCHDOG_EN
    logic [1:0] err_stage_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_stage_q <= OWN_NONE;
        end else if ((state_d == ST_GAUSS) && (state_q != ST_GAUSS)) begin
            err_stage_q <= OWN_NONE;
        end else if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) begin
            err_stage_q <= owner_of(state_q);
        end
    end

    assign err       = (state_q == ST_ERROR);
    assign err_stage = err_stage_q;
`else
    assign err       = 1'b0;
    assign err_stage = OWN_NONE;
`endif

    assign gauss_start  = (state_q == ST_GAUSS);
    assign detect_start = (state_q == ST_DETECT);
    assign match_start  = (state_q == ST_MATCH);
    assign done         = (state_q == ST_DONE);
    assign owner_sel    = owner_of(state_q);

endmodule

// File: tb/tb_sift_stage_sequencer.sv
module tb_sift_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        gauss_done = 1'b0;
    logic        detect_done = 1'b0;
    logic        match_done = 1'b0;
    logic [10:0] detect_kpt_addr = '0;
    logic        gauss_start, detect_start, match_start;
    logic [1:0]  owner_sel;
    logic [10:0] keypoint_num;
    logic        busy, done, err;
    logic [1:0]  err_stage;
    logic [23:0] last_cycles;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [10:0] kpt_model = '0;

    sift_stage_sequencer #(
        .CNT_W         (24),
        .KPT_W         (11),
        .TIMEOUT_LIMIT (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .gauss_done      (gauss_done),
        .detect_done     (detect_done),
        .match_done      (match_done),
        .detect_kpt_addr (detect_kpt_addr),
        .gauss_start     (gauss_start),
        .detect_start    (detect_start),
        .match_start     (match_start),
        .owner_sel       (owner_sel),
        .keypoint_num    (keypoint_num),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .err_stage       (err_stage),
        .last_cycles     (last_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // expected status word from the phase the run should be in:
    // {gauss_start, detect_start, match_start, busy, done, err, owner_sel}
    function automatic logic [31:0] status_exp(input int own, input bit dn, input bit er);
        logic [1:0] o;
        o = 2'(own);
        return {23'd0, own == 1, own == 2, own == 3, own != 0, dn, er, o};
    endfunction

    function automatic logic [31:0] status_obs();
        return {23'd0, gauss_start, detect_start, match_start, busy, done, err, owner_sel};
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_status"}, status_obs(), status_exp(0, 1'b0, 1'b0));
        chk({tag, "_kpt"}, 32'(keypoint_num), 32'd0);
        chk({tag, "_last"}, 32'(last_cycles), 32'd0);
        chk({tag, "_err_stage"}, 32'(err_stage), 32'd0);
    endtask

    // One full run: gauss lasts g cycles, detect d, match m (each >= 2).
    // With noise set, each stage's done is also raised on its entry cycle
    // (must be ignored) and start toggles randomly while busy (ignored).
    task automatic run_stages(input int g, input int d, input int m, input bit noise, input string tag);
        int          total;
        int          own;
        logic [10:0] addr;
        total = g + d + m;
        start = 1'b1;
        tick();
        start = 1'b0;
        kpt_model = '0;
        for (int t = 1; t <= total; t++) begin
            own = (t <= g) ? 1 : (t <= g + d) ? 2 : 3;
            chk({tag, "_status"}, status_obs(), status_exp(own, 1'b0, 1'b0));
            chk({tag, "_kpt"}, 32'(keypoint_num), 32'(kpt_model));
            addr            = 11'($urandom_range(2047, 0));
            detect_kpt_addr = addr;
            gauss_done      = (t == g) || (noise && t == 1);
            detect_done     = (t == g + d) || (noise && t == g + 1);
            match_done      = (t == total) || (noise && t == g + d + 1);
            start           = noise && ($urandom_range(1, 0) == 1);
            tick();
            if (own == 2) kpt_model = addr;
            if (t == g)     chk({tag, "_last_g"}, 32'(last_cycles), 32'(g));
            if (t == g + d) chk({tag, "_last_d"}, 32'(last_cycles), 32'(d));
            if (t == total) chk({tag, "_last_m"}, 32'(last_cycles), 32'(m));
        end
        gauss_done  = 1'b0;
        detect_done = 1'b0;
        match_done  = 1'b0;
        start       = 1'b0;
        chk({tag, "_done_status"}, status_obs(), status_exp(0, 1'b1, 1'b0));
        chk({tag, "_done_kpt"}, 32'(keypoint_num), 32'(kpt_model));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        tick();
        chk_reset_values("reset");

        // directed run 5/3/4
        run_stages(5, 3, 4, 1'b0, "basic");

        // stale gauss_done held across start: exactly 2 cycles of GAUSS
        gauss_done = 1'b1;
        tick();
        chk("stale_in_done", status_obs(), status_exp(0, 1'b1, 1'b0));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("stale_g1", status_obs(), status_exp(1, 1'b0, 1'b0));
        tick();
        chk("stale_g2", status_obs(), status_exp(1, 1'b0, 1'b0));
        tick();
        gauss_done = 1'b0;
        chk("stale_det", status_obs(), status_exp(2, 1'b0, 1'b0));
        chk("stale_last", 32'(last_cycles), 32'd2);

        // keypoint ramp 0..37 during DETECT (14 cycles, under the 16-cycle watchdog)
        for (int i = 0; i <= 13; i++) begin
            chk("ramp_status", status_obs(), status_exp(2, 1'b0, 1'b0));
            detect_kpt_addr = (i == 13) ? 11'd37 : 11'(3 * i);
            detect_done     = (i == 13);
            tick();
        end
        detect_done = 1'b0;
        detect_kpt_addr = 11'd5;
        chk("ramp_match", status_obs(), status_exp(3, 1'b0, 1'b0));
        chk("ramp_kpt", 32'(keypoint_num), 32'd37);
        chk("ramp_last", 32'(last_cycles), 32'd14);
        repeat (3) begin
            tick();
            chk("ramp_kpt_hold", 32'(keypoint_num), 32'd37);
        end

        // abort and match_done together: abort wins
        abort = 1'b1;
        match_done = 1'b1;
        tick();
        abort = 1'b0;
        match_done = 1'b0;
        chk("abort_status", status_obs(), status_exp(0, 1'b0, 1'b0));
        chk("abort_kpt", 32'(keypoint_num), 32'd37);
        chk("abort_last", 32'(last_cycles), 32'd14);

        // watchdog: detect_done never arrives
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        gauss_done = 1'b1;
        tick();
        gauss_done = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk("wd_det", status_obs(), status_exp(2, 1'b0, 1'b0));
            tick();
        end
`ifdef SEQ_WATCHDOG_EN
        chk("wd_error", status_obs(), status_exp(0, 1'b0, 1'b1));
        chk("wd_err_stage", 32'(err_stage), 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wd_restart", status_obs(), status_exp(1, 1'b0, 1'b0));
        chk("wd_err_clr", 32'(err_stage), 32'd0);
`else
        chk("nowd_still_det", status_obs(), status_exp(2, 1'b0, 1'b0));
        chk("nowd_err_stage", 32'(err_stage), 32'd0);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("wd_abort", status_obs(), status_exp(0, 1'b0, 1'b0));

        // randomized runs against the phase-schedule model
        for (int r = 0; r < 20; r++) begin
            run_stages(int'($urandom_range(10, 2)), int'($urandom_range(10, 2)),
                       int'($urandom_range(10, 2)), 1'($urandom_range(1, 0)), "rand");
            if (r % 3 == 0) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("rand_abort", status_obs(), status_exp(0, 1'b0, 1'b0));
                chk("rand_abort_kpt", 32'(keypoint_num), 32'(kpt_model));
            end
        end

        // asynchronous reset in the middle of GAUSS
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_gauss", status_obs(), status_exp(1, 1'b0, 1'b0));
        #2 rst = 1'b1;
        #1;
        chk("async_gauss_start", 32'(gauss_start), 32'd0);
        chk_reset_values("async_rst");
        #3 rst = 1'b0;
        tick();
        chk_reset_values("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
